writeback_mem_responder: RTL and testbench
==========================================

Name: writeback_mem_responder

Overview:
- Responder end of the execute stage's store-back and load/store interfaces in the 3-stage pipeline.
- Owns the 16-entry architectural register file and the 256-word data memory.
- Completes register write-backs (storeNow/storeDone), memory loads (readReq/valueReady) and memory stores (writeReq/writeDone) with four-phase handshakes.
- Provides two operand read ports to decode and a latched PSW copy.

Parameters:
DATA_W, 16, data word width
REG_AW, 4, register address width (2^REG_AW registers)
MEM_AW, 8, data memory address width (2^MEM_AW words)
MEM_LATENCY, 2, cycles from load acceptance to valueReady; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
destRegStore  in  REG_AW  write-back register index
destVal  in  DATA_W  write-back value
storeNow  in  1  write-back request; level, held until storeDone seen
storeDone  out  1  write-back acknowledge
memAddrLoadStore  in  MEM_AW  load/store address
memValueStore  in  DATA_W  store data
writeReq  in  1  memory store request; level
writeDone  out  1  memory store acknowledge
readReq  in  1  memory load request; level
memValueLoad  out  DATA_W  load data; valid while valueReady=1
valueReady  out  1  load acknowledge
rdAddr1, rdAddr2  in  REG_AW each  decode operand indices
rdVal1, rdVal2  out  DATA_W each  decode operand values
ProcessorStatusWord  in  DATA_W  PSW from execute
pswLatched  out  DATA_W  PSW captured at each accepted write-back
powerdown  in  1  stop accepting new requests
powerdownAck  out  1  high when powerdown=1 and both channels are idle

Behaviour:
- Reset (rst=0, asynchronous): all registers and memory words cleared to 0; storeDone, writeDone, valueReady, powerdownAck, memValueLoad and pswLatched all 0; both FSMs go to IDLE.
- Register channel FSM, states R_IDLE and R_ACK:
  - In R_IDLE with storeNow=1 and powerdown=0: on that edge, regfile[destRegStore] <= destVal and pswLatched <= ProcessorStatusWord; go to R_ACK; storeDone=1 from the next cycle.
  - In R_ACK: storeDone stays 1 while storeNow=1; when storeNow=0, return to R_IDLE with storeDone=0 on that edge.
  - Exactly one write per handshake.
- Memory channel FSM, states M_IDLE, M_WAIT, M_RACK and M_WACK:
  - M_IDLE with writeReq=1 (and powerdown=0): mem[addr] <= memValueStore on that edge; go to M_WACK with writeDone=1.
  - Else M_IDLE with readReq=1: latch the address, load counter = MEM_LATENCY-1, go to M_WAIT.
  - writeReq wins over readReq when both are high; the read is served after the write handshake closes.
  - M_WAIT: decrement each cycle. At 0, memValueLoad <= mem[latched addr] and valueReady <= 1; go to M_RACK. valueReady therefore rises exactly MEM_LATENCY cycles after acceptance.
  - M_RACK and M_WACK: hold the ack and data while the request is high; when the request drops, return to M_IDLE with the ack cleared on that edge. memValueLoad holds its last value afterwards.
  - Load data is sampled at the end of M_WAIT, so a store accepted earlier to the same address is visible.
- Request dropped in M_WAIT (protocol error): abort to M_IDLE; valueReady is never raised.
- Operand read ports are combinational with bypass: if R_IDLE accepts a write this cycle and rdAddrN == destRegStore, rdValN = destVal; otherwise rdValN = regfile[rdAddrN].
- Both channels run independently and may complete on the same cycle.
- powerdown only blocks acceptance in the IDLE states; in-flight handshakes complete normally. powerdownAck = powerdown && R_IDLE && M_IDLE, registered (one cycle lag).
- Reset mid-handshake forces IDLE immediately. A write already performed stays cleared by reset, since reset zeroes storage.
- Addresses use full width; there is no out-of-range case. Values are stored unmodified.

Test Plan:
- Write-back: storeNow=1, destRegStore=12, destVal=54 -> storeDone=1 one cycle later; drop storeNow -> storeDone=0 next edge; rdAddr1=12 gives rdVal1=54.
- Bypass: rdAddr2=13 while the write of 9 to r13 is being accepted -> rdVal2=9 in the same cycle.
- Store then load: writeReq with addr=180, data=45 -> writeDone; after it closes, readReq at addr=180 -> valueReady exactly 2 cycles after acceptance with memValueLoad=45.
- Simultaneous requests: writeReq and readReq both high at addr=7, data=0x00FF -> write acknowledged first; the following load returns 0x00FF.
- Powerdown: assert powerdown during M_WAIT -> the load completes, a new storeNow is ignored, and powerdownAck=1 once both channels are idle.
- Reset: pull rst low during M_RACK -> valueReady=0 immediately; after release, reading r12 and mem[180] returns 0.

Source files
------------

// File: rtl/writeback_mem_responder.sv
// Write-back / load-store responder: register file, data memory,
// operand read ports and PSW latch behind four-phase handshakes.
module writeback_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 4,
    parameter int MEM_AW      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] destRegStore,
    input  logic [DATA_W-1:0] destVal,
    input  logic              storeNow,
    output logic              storeDone,
    input  logic [MEM_AW-1:0] memAddrLoadStore,
    input  logic [DATA_W-1:0] memValueStore,
    input  logic              writeReq,
    output logic              writeDone,
    input  logic              readReq,
    output logic [DATA_W-1:0] memValueLoad,
    output logic              valueReady,
    input  logic [REG_AW-1:0] rdAddr1,
    input  logic [REG_AW-1:0] rdAddr2,
    output logic [DATA_W-1:0] rdVal1,
    output logic [DATA_W-1:0] rdVal2,
    input  logic [DATA_W-1:0] ProcessorStatusWord,
    output logic [DATA_W-1:0] pswLatched,
    input  logic              powerdown,
    output logic              powerdownAck
);

    localparam int NREG  = 1 << REG_AW;
    localparam int NMEM  = 1 << MEM_AW;
    localparam int CNT_W = 4;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } r_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_RACK,
        M_WACK
    } m_state_t;

    r_state_t          r_state_q;
    m_state_t          m_state_q;
    logic [DATA_W-1:0] regfile_q [NREG];
    logic [DATA_W-1:0] mem_q     [NMEM];
    logic [MEM_AW-1:0] raddr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              store_done_q;
    logic              write_done_q;
    logic              value_ready_q;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] psw_q;
    logic              pd_ack_q;
    logic              r_accept;

    assign r_accept = (r_state_q == R_IDLE) && storeNow && !powerdown;

    // Operand reads see a write-back being accepted this very cycle.
    always_comb begin
        rdVal1 = regfile_q[rdAddr1];
        rdVal2 = regfile_q[rdAddr2];
        if (r_accept && (rdAddr1 == destRegStore)) rdVal1 = destVal;
        if (r_accept && (rdAddr2 == destRegStore)) rdVal2 = destVal;
    end

    // Register channel: one regfile write and PSW capture per handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
            r_state_q    <= R_IDLE;
            store_done_q <= 1'b0;
            psw_q        <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (r_accept) begin
                        regfile_q[destRegStore] <= destVal;
                        psw_q        <= ProcessorStatusWord;
                        store_done_q <= 1'b1;
                        r_state_q    <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!storeNow) begin
                        store_done_q <= 1'b0;
                        r_state_q    <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Memory channel: stores complete at once, loads after a fixed delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NMEM; i++) mem_q[i] <= '0;
            m_state_q     <= M_IDLE;
            raddr_q       <= '0;
            cnt_q         <= '0;
            write_done_q  <= 1'b0;
            value_ready_q <= 1'b0;
            load_q        <= '0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    if (!powerdown && writeReq) begin
                        mem_q[memAddrLoadStore] <= memValueStore;
                        write_done_q <= 1'b1;
                        m_state_q    <= M_WACK;
                    end else if (!powerdown && readReq) begin
                        raddr_q   <= memAddrLoadStore;
                        cnt_q     <= CNT_W'(MEM_LATENCY - 1);
                        m_state_q <= M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (!readReq) begin
                        m_state_q <= M_IDLE;
                    end else if (cnt_q == '0) begin
                        load_q        <= mem_q[raddr_q];
                        value_ready_q <= 1'b1;
                        m_state_q     <= M_RACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                M_RACK: begin
                    if (!readReq) begin
                        value_ready_q <= 1'b0;
                        m_state_q     <= M_IDLE;
                    end
                end
                M_WACK: begin
                    if (!writeReq) begin
                        write_done_q <= 1'b0;
                        m_state_q    <= M_IDLE;
                    end
                end
                default: m_state_q <= M_IDLE;
            endcase
        end
    end

    // Powerdown acknowledge, one cycle behind the idle condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pd_ack_q <= 1'b0;
        end else begin
            pd_ack_q <= powerdown && (r_state_q == R_IDLE) &&
                        (m_state_q == M_IDLE);
        end
    end

    assign storeDone    = store_done_q;
    assign writeDone    = write_done_q;
    assign valueReady   = value_ready_q;
    assign memValueLoad = load_q;
    assign pswLatched   = psw_q;
    assign powerdownAck = pd_ack_q;

endmodule

// File: tb/tb_writeback_mem_responder.sv
// Self-checking bench for writeback_mem_responder: vector table,
// hand-written corner sequences and a randomized model comparison.
module tb_writeback_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  destRegStore;
    logic [15:0] destVal;
    logic        storeNow;
    logic        storeDone;
    logic [7:0]  memAddrLoadStore;
    logic [15:0] memValueStore;
    logic        writeReq;
    logic        writeDone;
    logic        readReq;
    logic [15:0] memValueLoad;
    logic        valueReady;
    logic [3:0]  rdAddr1;
    logic [3:0]  rdAddr2;
    logic [15:0] rdVal1;
    logic [15:0] rdVal2;
    logic [15:0] psw;
    logic [15:0] pswLatched;
    logic        powerdown;
    logic        powerdownAck;

    writeback_mem_responder #(
        .DATA_W(16), .REG_AW(4), .MEM_AW(8), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .destRegStore(destRegStore),
        .destVal(destVal),
        .storeNow(storeNow),
        .storeDone(storeDone),
        .memAddrLoadStore(memAddrLoadStore),
        .memValueStore(memValueStore),
        .writeReq(writeReq),
        .writeDone(writeDone),
        .readReq(readReq),
        .memValueLoad(memValueLoad),
        .valueReady(valueReady),
        .rdAddr1(rdAddr1),
        .rdAddr2(rdAddr2),
        .rdVal1(rdVal1),
        .rdVal2(rdVal2),
        .ProcessorStatusWord(psw),
        .pswLatched(pswLatched),
        .powerdown(powerdown),
        .powerdownAck(powerdownAck)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain storage arrays.
    logic [15:0] m_reg [16];
    logic [15:0] m_mem [256];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int op;    // 0 write-back, 1 store, 2 load, 3 operand read
        int addr;
        int data;
        int exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    task automatic do_wb(input logic [3:0] r, input logic [15:0] v,
                         input logic [15:0] p);
        destRegStore = r;
        destVal      = v;
        psw          = p;
        storeNow     = 1'b1;
        step();
        check("wb_done", {31'b0, storeDone}, 1);
        psw      = ~p;
        storeNow = 1'b0;
        step();
        check("wb_close", {31'b0, storeDone}, 0);
        check("wb_psw", {16'b0, pswLatched}, {16'b0, p});
        m_reg[r] = v;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] v);
        memAddrLoadStore = a;
        memValueStore    = v;
        writeReq         = 1'b1;
        step();
        check("st_done", {31'b0, writeDone}, 1);
        writeReq = 1'b0;
        step();
        check("st_close", {31'b0, writeDone}, 0);
        m_mem[a] = v;
    endtask

    // Load with latency measurement; valueReady must rise LAT cycles
    // after the accepting edge.
    task automatic do_load(input logic [7:0] a, output logic [15:0] v);
        int n;
        memAddrLoadStore = a;
        readReq          = 1'b1;
        step();
        n = 0;
        while (!valueReady && n < 40) begin
            step();
            n++;
        end
        check("ld_latency", n, LAT);
        v       = memValueLoad;
        readReq = 1'b0;
        step();
        check("ld_close", {31'b0, valueReady}, 0);
        check("ld_hold", {16'b0, memValueLoad}, {16'b0, v});
    endtask

    task automatic do_rd(input logic [3:0] r1, input logic [3:0] r2);
        rdAddr1 = r1;
        rdAddr2 = r2;
        #1;
        check("rd1", {16'b0, rdVal1}, {16'b0, m_reg[r1]});
        check("rd2", {16'b0, rdVal2}, {16'b0, m_reg[r2]});
    endtask

    initial begin
        logic [15:0] got;
        logic [3:0]  ra;
        logic [7:0]  ma;
        int          n;

        rst_n            = 1'b0;
        destRegStore     = '0;
        destVal          = '0;
        storeNow         = 1'b0;
        memAddrLoadStore = '0;
        memValueStore    = '0;
        writeReq         = 1'b0;
        readReq          = 1'b0;
        rdAddr1          = '0;
        rdAddr2          = '0;
        psw              = 16'hBEEF;
        powerdown        = 1'b0;
        model_clear();

        step();
        step();
        check("rst_storeDone", {31'b0, storeDone}, 0);
        check("rst_writeDone", {31'b0, writeDone}, 0);
        check("rst_valueReady", {31'b0, valueReady}, 0);
        check("rst_pdAck", {31'b0, powerdownAck}, 0);
        check("rst_load", {16'b0, memValueLoad}, 0);
        check("rst_psw", {16'b0, pswLatched}, 0);
        rst_n = 1'b1;
        step();
        do_rd(4'd3, 4'd15);

        // Directed vector table.
        vecs.push_back('{0, 12, 54, 0});
        vecs.push_back('{3, 12, 0, 54});
        vecs.push_back('{1, 180, 45, 0});
        vecs.push_back('{2, 180, 0, 45});
        vecs.push_back('{0, 0, 16'hFFFF, 0});
        vecs.push_back('{3, 0, 0, 16'hFFFF});
        vecs.push_back('{3, 15, 0, 0});
        vecs.push_back('{1, 255, 16'hA5A5, 0});
        vecs.push_back('{2, 255, 0, 16'hA5A5});
        vecs.push_back('{2, 0, 0, 0});
        foreach (vecs[i]) begin
            case (vecs[i].op)
                0: do_wb(4'(vecs[i].addr), 16'(vecs[i].data),
                         16'(vecs[i].data) ^ 16'h5A5A);
                1: do_store(8'(vecs[i].addr), 16'(vecs[i].data));
                2: begin
                    do_load(8'(vecs[i].addr), got);
                    check("vec_load", {16'b0, got}, 32'(vecs[i].exp));
                end
                default: begin
                    rdAddr1 = 4'(vecs[i].addr);
                    rdAddr2 = 4'(vecs[i].addr);
                    #1;
                    check("vec_rd1", {16'b0, rdVal1}, 32'(vecs[i].exp));
                    check("vec_rd2", {16'b0, rdVal2}, 32'(vecs[i].exp));
                end
            endcase
        end

        // Bypass: operand port sees the value being accepted.
        rdAddr2      = 4'd13;
        destRegStore = 4'd13;
        destVal      = 16'd9;
        storeNow     = 1'b1;
        #1;
        check("bypass", {16'b0, rdVal2}, 9);
        step();
        check("bypass_done", {31'b0, storeDone}, 1);
        storeNow = 1'b0;
        step();
        m_reg[13] = 16'd9;
        check("bypass_after", {16'b0, rdVal2}, 9);

        // Simultaneous write and read: store wins, load follows.
        memAddrLoadStore = 8'd7;
        memValueStore    = 16'h00FF;
        writeReq         = 1'b1;
        readReq          = 1'b1;
        step();
        check("sim_wdone", {31'b0, writeDone}, 1);
        check("sim_noready", {31'b0, valueReady}, 0);
        writeReq = 1'b0;
        step();
        check("sim_wclose", {31'b0, writeDone}, 0);
        m_mem[7] = 16'h00FF;
        step();
        n = 0;
        while (!valueReady && n < 40) begin
            step();
            n++;
        end
        check("sim_latency", n, LAT);
        check("sim_data", {16'b0, memValueLoad}, 32'h00FF);
        readReq = 1'b0;
        step();
        check("sim_close", {31'b0, valueReady}, 0);

        // Powerdown during a load.
        do_store(8'd50, 16'h1234);
        memAddrLoadStore = 8'd50;
        readReq          = 1'b1;
        step();
        powerdown    = 1'b1;
        destRegStore = 4'd5;
        destVal      = 16'd777;
        storeNow     = 1'b1;
        rdAddr1      = 4'd5;
        step();
        check("pd_busy_ack", {31'b0, powerdownAck}, 0);
        step();
        check("pd_ready", {31'b0, valueReady}, 1);
        check("pd_data", {16'b0, memValueLoad}, 32'h1234);
        check("pd_nostore", {31'b0, storeDone}, 0);
        readReq = 1'b0;
        step();
        step();
        check("pd_ack", {31'b0, powerdownAck}, 1);
        check("pd_nostore2", {31'b0, storeDone}, 0);
        check("pd_reg", {16'b0, rdVal1}, {16'b0, m_reg[5]});
        storeNow  = 1'b0;
        powerdown = 1'b0;
        step();
        check("pd_ack_off", {31'b0, powerdownAck}, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            ra = 4'($urandom_range(0, 15));
            ma = 8'($urandom_range(100, 115));
            case ($urandom_range(0, 3))
                0: do_wb(ra, 16'($urandom), 16'($urandom));
                1: do_store(ma, 16'($urandom));
                2: begin
                    do_load(ma, got);
                    check("rnd_load", {16'b0, got}, {16'b0, m_mem[ma]});
                end
                default: do_rd(ra, 4'($urandom_range(0, 15)));
            endcase
        end

        // Reset while a load is acknowledged.
        memAddrLoadStore = 8'd180;
        readReq          = 1'b1;
        step();
        n = 0;
        while (!valueReady && n < 40) begin
            step();
            n++;
        end
        check("rr_data", {16'b0, memValueLoad}, 45);
        rst_n = 1'b0;
        #1;
        check("rr_ready", {31'b0, valueReady}, 0);
        check("rr_load", {16'b0, memValueLoad}, 0);
        readReq = 1'b0;
        step();
        rst_n = 1'b1;
        model_clear();
        step();
        rdAddr1 = 4'd12;
        #1;
        check("rr_reg12", {16'b0, rdVal1}, 0);
        do_load(8'd180, got);
        check("rr_mem180", {16'b0, got}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
